lsu_channel_bridge: RTL

Registered, per-consumer request/response bridge between the LSU channels of the compute cores and the data-memory `arbiter_cache`. It replaces the free-running pass-through registers between core-local and global LSU buses. Each consumer gets a small handshake FSM that holds one outstanding read or write, forwards it to the controller and returns the response. Status outputs expose per-consumer busy state and an in-flight count.

---
 rtl/lsu_channel_bridge_if.sv | 59 +++++
 rtl/lsu_channel_bridge.sv | 129 ++++++++++++
 2 files changed

// File: rtl/lsu_channel_bridge_if.sv
// Request/response bundle between LSU channels and the data-memory controller.
// Also carries the bridge status outputs.
interface lsu_channel_bridge_if #(
  parameter int NUM_CONSUMERS = 8,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  localparam int CW = $clog2(NUM_CONSUMERS) + 1;

  logic [NUM_CONSUMERS-1:0] lsu_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] lsu_read_address;
  logic [NUM_CONSUMERS-1:0] lsu_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] lsu_read_data;
  logic [NUM_CONSUMERS-1:0] lsu_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] lsu_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] lsu_write_data;
  logic [NUM_CONSUMERS-1:0] lsu_write_ready;

  logic [NUM_CONSUMERS-1:0] mem_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CONSUMERS-1:0] mem_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] mem_read_data;
  logic [NUM_CONSUMERS-1:0] mem_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CONSUMERS-1:0] mem_write_ready;

  logic [NUM_CONSUMERS-1:0] busy;
  logic [CW-1:0] inflight_count;
  logic protocol_error;

  modport slave (
    input  lsu_read_valid, lsu_read_address,
    input  lsu_write_valid, lsu_write_address,
    input  lsu_write_data,
    input  mem_read_ready, mem_read_data,
    input  mem_write_ready,
    output lsu_read_ready, lsu_read_data,
    output lsu_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address,
    output mem_write_data,
    output busy, inflight_count, protocol_error
  );

  modport master (
    output lsu_read_valid, lsu_read_address,
    output lsu_write_valid, lsu_write_address,
    output lsu_write_data,
    output mem_read_ready, mem_read_data,
    output mem_write_ready,
    input  lsu_read_ready, lsu_read_data,
    input  lsu_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address,
    input  mem_write_data,
    input  busy, inflight_count, protocol_error
  );
endinterface

// File: rtl/lsu_channel_bridge.sv
// Registered per-consumer LSU <-> data-memory bridge.
// One outstanding read or write per consumer, read wins on a tie.
module lsu_channel_bridge #(
  parameter int NUM_CONSUMERS = 8,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input logic clk,
  input logic reset,
  lsu_channel_bridge_if.slave bus
);
  localparam int N = NUM_CONSUMERS;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP
  } state_e;

  state_e st_q [N];
  state_e st_d [N];
  logic [N-1:0] abort_q, abort_d;
  logic [N-1:0][ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [N-1:0][ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [N-1:0][DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [N-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;

  always_comb begin
    abort_d = abort_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    err_d = err_q;
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      st_d[i] = st_q[i];
      unique case (st_q[i])
        IDLE: begin
          abort_d[i] = 1'b0;
          if (bus.lsu_read_valid[i]) begin
            st_d[i] = RD_REQ;
            rd_addr_d[i] = bus.lsu_read_address[i];
          end else if (bus.lsu_write_valid[i]) begin
            st_d[i] = WR_REQ;
            wr_addr_d[i] = bus.lsu_write_address[i];
            wr_data_d[i] = bus.lsu_write_data[i];
          end
        end
        RD_REQ: begin
          abort_d[i] = abort_q[i] | ~bus.lsu_read_valid[i];
          if (bus.mem_read_ready[i]) begin
            st_d[i] = RD_RESP;
            if (abort_d[i]) err_d = 1'b1;
            else rd_data_d[i] = bus.mem_read_data[i];
          end
        end
        // an aborted response only waits for the controller to let go
        RD_RESP: begin
          if ((abort_q[i] | ~bus.lsu_read_valid[i])
              & ~bus.mem_read_ready[i])
            st_d[i] = IDLE;
        end
        WR_REQ: begin
          abort_d[i] = abort_q[i] | ~bus.lsu_write_valid[i];
          if (bus.mem_write_ready[i]) begin
            st_d[i] = WR_RESP;
            if (abort_d[i]) err_d = 1'b1;
          end
        end
        WR_RESP: begin
          if ((abort_q[i] | ~bus.lsu_write_valid[i])
              & ~bus.mem_write_ready[i])
            st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
      if (st_q[i] == RD_REQ || st_q[i] == WR_REQ)
        cnt_d = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) st_q[i] <= IDLE;
      abort_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) st_q[i] <= st_d[i];
      abort_q <= abort_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    bus.mem_read_valid = '0;
    bus.mem_write_valid = '0;
    bus.lsu_read_ready = '0;
    bus.lsu_write_ready = '0;
    bus.busy = '0;
    for (int i = 0; i < N; i++) begin
      bus.mem_read_valid[i] = st_q[i] == RD_REQ;
      bus.mem_write_valid[i] = st_q[i] == WR_REQ;
      bus.lsu_read_ready[i] =
        (st_q[i] == RD_RESP) & ~abort_q[i];
      bus.lsu_write_ready[i] =
        (st_q[i] == WR_RESP) & ~abort_q[i];
      bus.busy[i] = st_q[i] != IDLE;
    end
  end

  assign bus.mem_read_address = rd_addr_q;
  assign bus.mem_write_address = wr_addr_q;
  assign bus.mem_write_data = wr_data_q;
  assign bus.lsu_read_data = rd_data_q;
  assign bus.inflight_count = cnt_q;
  assign bus.protocol_error = err_q;
endmodule
